hamming_stream_codec: RTL and testbench

HAMMING_STREAM_CODEC -- requirements
Module: hamming_stream_codec

---
 rtl/hamming_pkg.sv | 19 +
 rtl/hamming_syndrome.sv | 23 ++
 rtl/hamming_stream_codec.sv | 189 ++++++++++++++++++
 tb/tb_hamming_stream_codec.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming codec constants and parity-width derivation
package hamming_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Smallest r such that 2^r >= data_w + r + 1.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 0;
        for (int k = 1; k < 31; k++) begin
            if (r == 0 && (1 << k) >= data_w + k + 1) begin
                r = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - XOR of position numbers of all set bits in a Hamming codeword
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 7,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int HAM_W  = DATA_W + PAR_W
) (
    input  logic [HAM_W-1:0] code_i,
    output logic [PAR_W-1:0] syndrome_o
);

    // With parity slots zeroed this yields the parity bits; on a received word it is the syndrome.
    always_comb begin
        syndrome_o = '0;
        for (int p = 1; p <= HAM_W; p++) begin
            if (code_i[p-1]) begin
                syndrome_o = syndrome_o ^ PAR_W'(p);
            end
        end
    end

endmodule

// File: rtl/hamming_stream_codec.sv
// rtl/hamming_stream_codec.sv - two-stage Hamming stream codec; HAMMING_SECDED_EN adds overall parity (SECDED)
module hamming_stream_codec
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 7,
    parameter int  CNT_W  = 16,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int HAM_W  = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
    localparam int CODE_W = HAM_W + 1
`else
    localparam int CODE_W = HAM_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_err_corr,
    output logic              out_err_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic              s1_valid_q, s1_mode_q;
    logic [HAM_W-1:0]  s1_code_q, s1_code_d, placed;
    logic [PAR_W-1:0]  s1_syn_q, syn_d;
    logic              out_valid_q, out_err_corr_q, out_err_uncorr_q;
    logic [CODE_W-1:0] out_data_q, res_data;
    logic [PAR_W-1:0]  out_syndrome_q, res_syn;
    logic              res_corr, res_uncorr, in_range;
    logic [HAM_W-1:0]  code_fix;
    logic [CNT_W-1:0]  corr_cnt_q, uncorr_cnt_q;
    logic              s1_adv, in_fire, out_fire;
    int                wr_idx, rd_idx;
`ifdef HAMMING_SECDED_EN
    logic              s1_ovp_q, ovp_d;
`endif

    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Scatter data bits LSB first into the non-power-of-two positions, parity slots left zero.
    always_comb begin
        placed = '0;
        wr_idx = 0;
        for (int p = 1; p <= HAM_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                placed[p-1] = in_data[wr_idx];
                wr_idx++;
            end
        end
    end

    assign s1_code_d = (in_mode == MODE_ENC) ? placed : in_data[HAM_W-1:0];

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .code_i     (s1_code_d),
        .syndrome_o (syn_d)
    );

`ifdef HAMMING_SECDED_EN
    // Encode: parity of the finished codeword; decode: parity over every received bit.
    assign ovp_d = (in_mode == MODE_ENC) ? (^placed ^ ^syn_d) : ^in_data;
`endif

    // Stage 1: capture accepted word with its syndrome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_ENC;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
`ifdef HAMMING_SECDED_EN
            s1_ovp_q   <= 1'b0;
`endif
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_mode_q  <= in_mode;
            s1_code_q  <= s1_code_d;
            s1_syn_q   <= syn_d;
`ifdef HAMMING_SECDED_EN
            s1_ovp_q   <= ovp_d;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2 datapath: insert parity for encode, classify and correct for decode.
    always_comb begin
        res_data   = '0;
        res_syn    = '0;
        res_corr   = 1'b0;
        res_uncorr = 1'b0;
        code_fix   = s1_code_q;
        rd_idx     = 0;
        in_range   = (s1_syn_q != '0) && (32'(s1_syn_q) <= HAM_W);
        if (s1_mode_q == MODE_ENC) begin
            for (int k = 0; k < PAR_W; k++) begin
                code_fix[(1 << k) - 1] = s1_syn_q[k];
            end
            res_data[HAM_W-1:0] = code_fix;
`ifdef HAMMING_SECDED_EN
            res_data[CODE_W-1] = s1_ovp_q;
`endif
        end else begin
            res_syn = s1_syn_q;
`ifdef HAMMING_SECDED_EN
            // Odd overall parity means a single error; even parity with s!=0 means a double error.
            if (s1_ovp_q) begin
                res_corr   = (s1_syn_q == '0) || in_range;
                res_uncorr = !res_corr;
            end else begin
                res_uncorr = (s1_syn_q != '0);
            end
`else
            res_corr   = in_range;
            res_uncorr = (s1_syn_q != '0) && !in_range;
`endif
            for (int p = 1; p <= HAM_W; p++) begin
                if (res_corr && in_range && 32'(s1_syn_q) == p) begin
                    code_fix[p-1] = ~code_fix[p-1];
                end
            end
            for (int p = 1; p <= HAM_W; p++) begin
                if ((p & (p - 1)) != 0) begin
                    res_data[rd_idx] = code_fix[p-1];
                    rd_idx++;
                end
            end
        end
    end

    // Stage 2: output register, only reloaded when stage 1 advances so a stalled word holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_syndrome_q   <= '0;
            out_err_corr_q   <= 1'b0;
            out_err_uncorr_q <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q      <= 1'b1;
            out_data_q       <= res_data;
            out_syndrome_q   <= res_syn;
            out_err_corr_q   <= res_corr;
            out_err_uncorr_q <= res_uncorr;
        end else if (out_ready) begin
            out_valid_q      <= 1'b0;
        end
    end

    // Saturating error counters, bumped at the output handshake; clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (cnt_clr) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (out_fire) begin
            if (out_err_corr_q && corr_cnt_q != '1) begin
                corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
            if (out_err_uncorr_q && uncorr_cnt_q != '1) begin
                uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_syndrome   = out_syndrome_q;
    assign out_err_corr   = out_err_corr_q;
    assign out_err_uncorr = out_err_uncorr_q;
    assign corr_cnt       = corr_cnt_q;
    assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_stream_codec.sv
// tb/tb_hamming_stream_codec.sv - directed self-checking bench for hamming_stream_codec (SEC or HAMMING_SECDED_EN)
module tb_hamming_stream_codec;

    localparam int DW   = 7;
    localparam int CNTW = 4;
`ifdef HAMMING_SECDED_EN
    localparam int CW = 12;
    localparam logic [CW-1:0] E01  = 12'h807;
    localparam logic [CW-1:0] E7F  = 12'hFFF;
    localparam logic [CW-1:0] E02  = 12'h819;
    localparam logic [CW-1:0] D027 = 12'h827;
`else
    localparam int CW = 11;
    localparam logic [CW-1:0] E01  = 11'h007;
    localparam logic [CW-1:0] E7F  = 11'h7FF;
    localparam logic [CW-1:0] E02  = 11'h019;
    localparam logic [CW-1:0] D027 = 11'h027;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_mode;
    logic [CW-1:0]   in_data;
    logic            out_valid, out_ready;
    logic [CW-1:0]   out_data;
    logic [3:0]      out_syndrome;
    logic            out_err_corr, out_err_uncorr;
    logic            cnt_clr;
    logic [CNTW-1:0] corr_cnt, uncorr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hamming_stream_codec #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mode        (in_mode),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_syndrome   (out_syndrome),
        .out_err_corr   (out_err_corr),
        .out_err_uncorr (out_err_uncorr),
        .cnt_clr        (cnt_clr),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt)
    );

    // Single word through an idle pipeline with out_ready high; entered and left at posedge+1.
    task automatic xfer(input logic m, input logic [CW-1:0] d, output logic [CW-1:0] od,
                        output logic [3:0] sy, output logic c, output logic u,
                        output logic ok, output int lat);
        int n;
        n = 0; ok = 1'b1; lat = 0;
        in_valid = 1'b1; in_mode = m; in_data = d;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid) ok = 1'b0;
        od = out_data; sy = out_syndrome; c = out_err_corr; u = out_err_uncorr;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (out_syndrome !== 4'd0 || out_err_corr !== 1'b0 || out_err_uncorr !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got syn=%0d c=%b u=%b want 0", out_syndrome, out_err_corr, out_err_uncorr); end
        n_checks++; if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_encode();
        logic [CW-1:0] od; logic [3:0] sy; logic c, u, ok; int lat;
        xfer(1'b0, CW'(7'h01), od, sy, c, u, ok, lat);
        n_checks++; if (!ok || lat != 2) begin n_fail++; $display("FAIL enc01_latency got ok=%b lat=%0d want 1/2", ok, lat); end
        n_checks++; if (od !== E01) begin n_fail++; $display("FAIL enc01_data got %h want %h", od, E01); end
        n_checks++; if (sy !== 4'd0 || c !== 1'b0 || u !== 1'b0) begin
            n_fail++; $display("FAIL enc01_flags got syn=%0d c=%b u=%b want 0", sy, c, u); end
        xfer(1'b0, CW'(7'h7F), od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== E7F) begin n_fail++; $display("FAIL enc7f_data got %h want %h", od, E7F); end
        // upper input bits are ignored when encoding
        xfer(1'b0, CW'(11'h781), od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== E01) begin n_fail++; $display("FAIL enc_upper_ignored got %h want %h", od, E01); end
        n_checks++; if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            n_fail++; $display("FAIL enc_no_count got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
    endtask

    task automatic test_decode_single();
        logic [CW-1:0] od; logic [3:0] sy; logic c, u, ok; int lat;
        xfer(1'b1, D027, od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== CW'(7'h01)) begin n_fail++; $display("FAIL dec027_data got %h want 001", od); end
        n_checks++; if (sy !== 4'd6) begin n_fail++; $display("FAIL dec027_syndrome got %0d want 6", sy); end
        n_checks++; if (c !== 1'b1 || u !== 1'b0) begin n_fail++; $display("FAIL dec027_flags got c=%b u=%b want 1/0", c, u); end
        n_checks++; if (corr_cnt !== 4'd1 || uncorr_cnt !== 4'd0) begin
            n_fail++; $display("FAIL dec027_counts got %0d/%0d want 1/0", corr_cnt, uncorr_cnt); end
    endtask

    task automatic test_decode_cases();
        logic [CW-1:0] od; logic [3:0] sy; logic c, u, ok; int lat;
`ifdef HAMMING_SECDED_EN
        xfer(1'b1, 12'hFFC, od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== CW'(7'h7F) || sy !== 4'd3) begin
            n_fail++; $display("FAIL decffc_data got %h syn=%0d want 07f syn=3", od, sy); end
        n_checks++; if (c !== 1'b0 || u !== 1'b1) begin n_fail++; $display("FAIL decffc_flags got c=%b u=%b want 0/1", c, u); end
        xfer(1'b1, 12'h7FF, od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== CW'(7'h7F) || sy !== 4'd0 || c !== 1'b1 || u !== 1'b0) begin
            n_fail++; $display("FAIL dec_ovp_only got %h syn=%0d c=%b u=%b want 07f 0 1 0", od, sy, c, u); end
`else
        xfer(1'b1, 11'h7FC, od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== CW'(7'h7E) || sy !== 4'd3) begin
            n_fail++; $display("FAIL dec7fc_data got %h syn=%0d want 07e syn=3", od, sy); end
        n_checks++; if (c !== 1'b1 || u !== 1'b0) begin n_fail++; $display("FAIL dec7fc_flags got c=%b u=%b want 1/0", c, u); end
`endif
        xfer(1'b1, E7F, od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== CW'(7'h7F) || sy !== 4'd0 || c !== 1'b0 || u !== 1'b0) begin
            n_fail++; $display("FAIL dec_clean got %h syn=%0d c=%b u=%b want 07f 0 0 0", od, sy, c, u); end
        // positions 4 and 8 set: syndrome 12 lies beyond the 11 codeword positions
        xfer(1'b1, CW'(11'h088), od, sy, c, u, ok, lat);
        n_checks++; if (!ok || od !== '0 || sy !== 4'd12 || c !== 1'b0 || u !== 1'b1) begin
            n_fail++; $display("FAIL dec_out_of_range got %h syn=%0d c=%b u=%b want 000 12 0 1", od, sy, c, u); end
`ifdef HAMMING_SECDED_EN
        n_checks++; if (corr_cnt !== 4'd2 || uncorr_cnt !== 4'd2) begin
            n_fail++; $display("FAIL dec_counts got %0d/%0d want 2/2", corr_cnt, uncorr_cnt); end
`else
        n_checks++; if (corr_cnt !== 4'd2 || uncorr_cnt !== 4'd1) begin
            n_fail++; $display("FAIL dec_counts got %0d/%0d want 2/1", corr_cnt, uncorr_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] exp_q[$];
        logic [CW-1:0] got_q[$];
        logic accept_now;
        int n;
        exp_q = '{E01, E7F, E02};
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = CW'(7'h01);
        @(posedge clk); #1;
        in_data = CW'(7'h7F);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_data = CW'(7'h02);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_blocked got %b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== E01 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cyc %0d got ov=%b data=%h rdy=%b want 1 %h 0", i, out_valid, out_data, in_ready, E01); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < 3 && n < 20) begin
            accept_now = in_valid && in_ready;
            if (out_valid) got_q.push_back(out_data);
            @(posedge clk); #1;
            if (accept_now) in_valid = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_order word %0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate got ov=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back_saturation();
        int stalls, outs;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        n_checks++; if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            n_fail++; $display("FAIL clr_counts got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
        stalls = 0; outs = 0;
        in_valid = 1'b1; in_mode = 1'b1; in_data = D027;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready) stalls++;
            if (out_valid) outs++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) outs++;
            @(posedge clk); #1;
        end
        n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        n_checks++; if (outs != 20) begin n_fail++; $display("FAIL b2b_outputs got %0d want 20", outs); end
        n_checks++; if (corr_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_corr_cnt got %0d want 15", corr_cnt); end
    endtask

    task automatic test_cnt_clr_priority();
        logic [CW-1:0] od; logic [3:0] sy; logic c, u, ok; int lat;
        in_valid = 1'b1; in_mode = 1'b1; in_data = D027;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_err_corr !== 1'b1) begin
            n_fail++; $display("FAIL clr_setup got ov=%b c=%b want 1/1", out_valid, out_err_corr); end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        n_checks++; if (corr_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_wins got %0d want 0", corr_cnt); end
        xfer(1'b1, D027, od, sy, c, u, ok, lat);
        n_checks++; if (!ok || corr_cnt !== 4'd1) begin n_fail++; $display("FAIL clr_resume got %0d want 1", corr_cnt); end
    endtask

    task automatic test_reset_inflight();
        int outs;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b1; in_data = D027;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_setup got ov=%b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset got ov=%b rdy=%b want 0/1", out_valid, in_ready); end
        n_checks++; if (corr_cnt !== '0 || out_data !== '0) begin
            n_fail++; $display("FAIL async_reset_state got cnt=%0d data=%h want 0/0", corr_cnt, out_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) outs++;
            @(posedge clk); #1;
        end
        n_checks++; if (outs != 0 || corr_cnt !== '0) begin
            n_fail++; $display("FAIL inflight_discarded got outs=%0d cnt=%0d want 0/0", outs, corr_cnt); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        test_reset();
        test_encode();
        test_decode_single();
        test_decode_cases();
        test_backpressure();
        test_back_to_back_saturation();
        test_cnt_clr_priority();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
